// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// datapath select encodings and the control word driven by the output decoder.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC_R  = 4'd6;
  localparam logic [3:0] S_EXEC_I  = 4'd7;
  localparam logic [3:0] S_ALUWB   = 4'd8;
  localparam logic [3:0] S_BEQ     = 4'd9;
  localparam logic [3:0] S_JAL     = 4'd10;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MEMDATA   = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  // ack_gated marks strobes that may only fire in the cycle memory acknowledges.
  typedef struct packed {
    logic        mem_req;
    logic        adr_src;
    logic        ir_write;
    logic        pc_update;
    logic        branch;
    logic        reg_write;
    logic        mem_write;
    logic        instr_done;
    logic        ack_gated;
    src_a_e      alu_src_a;
    src_b_e      alu_src_b;
    alu_op_e     alu_op;
    result_src_e result_src;
  } ctrl_word_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_legal_op(input logic [6:0] opcode);
    case (opcode)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_out_deco.sv
// Moore output decoder: maps the controller state onto its datapath control word.
module mc_out_deco
  import riscv_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_word_t cw
);

  // Unused encodings fall through with an all-zero word so no strobe fires.
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_req    = 1'b1;
        cw.ir_write   = 1'b1;
        cw.pc_update  = 1'b1;
        cw.ack_gated  = 1'b1;
        cw.alu_src_b  = SRCB_FOUR;
        cw.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        cw.alu_src_a = SRCA_OLDPC;
        cw.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        cw.mem_req = 1'b1;
        cw.adr_src = 1'b1;
      end
      S_MEMWB: begin
        cw.result_src = RES_MEMDATA;
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_req    = 1'b1;
        cw.adr_src    = 1'b1;
        cw.mem_write  = 1'b1;
        cw.instr_done = 1'b1;
        cw.ack_gated  = 1'b1;
      end
      S_EXEC_R: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_RS2;
        cw.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_BEQ: begin
        cw.alu_src_a  = SRCA_RS1;
        cw.alu_src_b  = SRCB_RS2;
        cw.alu_op     = ALU_SUB;
        cw.branch     = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_JAL: begin
        cw.alu_src_a = SRCA_OLDPC;
        cw.alu_src_b = SRCB_FOUR;
        cw.pc_update = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I sequencing controller: state register, next-state logic and
// the few Mealy terms (memAck gating, branch & zero, illegal opcode in Decode).
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int STATE_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            memAck,
  output logic            memReq,
  output logic            adrSrc,
  output logic            irWrite,
  output logic            pcWrite,
  output logic            regWrite,
  output logic            memWrite,
  output logic [1:0]      aluSrcA,
  output logic [1:0]      aluSrcB,
  output logic [1:0]      aluOp,
  output logic [1:0]      resultSrc,
  output logic [1:0]      immSrc,
  output logic            instrDone,
  output logic            illegalOp
);

  logic [STATE_W-1:0] state_q, state_d;
  ctrl_word_t         cw;
  logic               ack_ok;
  logic               decode_illegal;

  mc_out_deco u_deco (
    .state (state_q),
    .cw    (cw)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = memAck ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMREAD;
      S_MEMREAD: state_d = memAck ? S_MEMWB : S_MEMREAD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = memAck ? S_FETCH : S_MEMWR;
      S_EXEC_R:  state_d = S_ALUWB;
      S_EXEC_I:  state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BEQ:     state_d = S_FETCH;
      S_JAL:     state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign ack_ok         = !cw.ack_gated || memAck;
  assign decode_illegal = (state_q == S_DECODE) && !is_legal_op(op);

  // Outputs are forced quiet while rst_n is low so an aborted store stops at once.
  always_comb begin
    memReq    = 1'b0;
    adrSrc    = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    memWrite  = 1'b0;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    resultSrc = 2'b00;
    immSrc    = 2'b00;
    instrDone = 1'b0;
    illegalOp = 1'b0;
    if (rst_n) begin
      memReq    = cw.mem_req;
      adrSrc    = cw.adr_src;
      irWrite   = cw.ir_write & ack_ok;
      pcWrite   = (cw.pc_update & ack_ok) | (cw.branch & zero);
      regWrite  = cw.reg_write;
      memWrite  = cw.mem_write;
      aluSrcA   = cw.alu_src_a;
      aluSrcB   = cw.alu_src_b;
      aluOp     = cw.alu_op;
      resultSrc = cw.result_src;
      immSrc    = imm_src_of(op);
      instrDone = (cw.instr_done & ack_ok) | decode_illegal;
      illegalOp = decode_illegal;
    end
  end

endmodule
